muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath, successor to the single-cycle combinational ALU.
- Executes MULT, MULTU, DIV and DIVU over N+1 clocks using a start/busy/done handshake.
- Holds architectural HI/LO registers, readable for MFHI/MFLO and writable for MTHI/MTLO.
- Sits beside the ALU. The control unit stalls the PC while busy is high.

---
 rtl/muldiv_unit_pkg.sv | 15 +
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_SIGN = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; one result bit per clock,
// N iterations plus a sign-fix cycle, start/busy/done handshake.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         flush,
    input  logic         hi_wen,
    input  logic         lo_wen,
    input  logic [N-1:0] wd,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done
);

    localparam int              CW   = $clog2(N);
    localparam int              AW   = 2 * N + 1;
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    md_state_e     state_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] acc_q;
    logic [N-1:0]  opnd_q;
    logic [N-1:0]  hi_q;
    logic [N-1:0]  lo_q;
    logic          div_q;
    logic          neg_res_q;
    logic          neg_a_q;
    logic          busy_q;
    logic          done_q;

    logic          op_signed_d;
    logic          a_neg_d;
    logic          b_neg_d;
    logic [N-1:0]  a_mag_d;
    logic [N-1:0]  b_mag_d;

    assign op_signed_d = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg_d     = op_signed_d & inA[N-1];
    assign b_neg_d     = op_signed_d & inB[N-1];
    assign a_mag_d     = a_neg_d ? -inA : inA;
    assign b_mag_d     = b_neg_d ? -inB : inB;

    // Multiply: acc = {carry, partial high, multiplier shifting out}; addend is opnd_q.
    logic [N:0]    mul_sum_d;
    logic [AW-1:0] mul_next_d;

    assign mul_sum_d  = {1'b0, acc_q[2*N-1:N]} + {1'b0, opnd_q};
    assign mul_next_d = acc_q[0] ? {1'b0, mul_sum_d, acc_q[N-1:1]}
                                 : {1'b0, acc_q[AW-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}; divisor is opnd_q.
    logic [N:0]    div_shift_d;
    logic [N:0]    div_diff_d;
    logic          div_ge_d;
    logic [AW-1:0] div_next_d;

    assign div_shift_d = {acc_q[2*N-1:N], acc_q[N-1]};
    assign div_diff_d  = div_shift_d - {1'b0, opnd_q};
    assign div_ge_d    = div_shift_d >= {1'b0, opnd_q};
    assign div_next_d  = div_ge_d ? {div_diff_d,  acc_q[N-2:0], 1'b1}
                                  : {div_shift_d, acc_q[N-2:0], 1'b0};

    // A zero divisor leaves quotient all ones and remainder = |dividend|; the
    // remainder's dividend-sign fix then restores inA exactly as it was given.
    logic [2*N-1:0] prod_fix_d;
    logic [N-1:0]   quot_fix_d;
    logic [N-1:0]   rem_fix_d;
    logic [N-1:0]   res_hi_d;
    logic [N-1:0]   res_lo_d;

    assign prod_fix_d = neg_res_q ? -acc_q[2*N-1:0] : acc_q[2*N-1:0];
    assign quot_fix_d = (neg_res_q && (opnd_q != '0)) ? -acc_q[N-1:0] : acc_q[N-1:0];
    assign rem_fix_d  = neg_a_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
    assign res_hi_d   = div_q ? rem_fix_d  : prod_fix_d[2*N-1:N];
    assign res_lo_d   = div_q ? quot_fix_d : prod_fix_d[N-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (hi_wen) hi_q <= wd;
                    if (lo_wen) lo_q <= wd;
                    if (start && !flush) begin
                        div_q     <= op[1];
                        neg_res_q <= a_neg_d ^ b_neg_d;
                        neg_a_q   <= a_neg_d;
                        opnd_q    <= op[1] ? b_mag_d : a_mag_d;
                        acc_q     <= {{(N+1){1'b0}}, (op[1] ? a_mag_d : b_mag_d)};
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end else begin
                        acc_q   <= div_q ? div_next_d : mul_next_d;
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST) state_q <= MD_SIGN;
                    end
                end
                MD_SIGN: begin
                    busy_q  <= 1'b0;
                    state_q <= MD_IDLE;
                    if (!flush) begin
                        hi_q   <= res_hi_d;
                        lo_q   <= res_lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed scenarios plus randomized ops against a 64-bit arithmetic model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        flush;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] wd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    muldiv_unit #(.N(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .inA   (inA),
        .inB   (inB),
        .flush (flush),
        .hi_wen(hi_wen),
        .lo_wen(lo_wen),
        .wd    (wd),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain 64-bit arithmetic on the architectural operand values.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        mhi = '0;
        mlo = '0;
        case (o)
            MD_MULT:  begin sp = sa * sb; mhi = sp[63:32]; mlo = sp[31:0]; end
            MD_MULTU: begin up = ua * ub; mhi = up[63:32]; mlo = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    mhi = a;
                    mlo = 32'hFFFF_FFFF;
                end else if (o == MD_DIV) begin
                    sq = sa / sb; sr = sa % sb;
                    mhi = sr[31:0]; mlo = sq[31:0];
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    mhi = ur[31:0]; mlo = uq[31:0];
                end
            end
        endcase
    endfunction

    // Issues one op at the current negedge and returns at the negedge where done is seen
    // (or after a bounded wait). Operand inputs are scrambled while the op is in flight.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit mt, input logic [31:0] mt_d,
                          output int lat, output logic busy_k,
                          output logic [31:0] hi_k, output logic [31:0] lo_k);
        op = o; inA = a; inB = b; start = 1'b1;
        hi_wen = mt; lo_wen = mt; wd = mt_d;
        @(negedge clock);
        start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
        busy_k = busy; hi_k = hi; lo_k = lo;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            inA = $urandom; inB = $urandom;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 2'b00; inA = '0; inB = '0;
        flush = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0; wd = '0;
        #1;
        vectors++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want all zero", hi, lo, busy, done);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        int lat; logic bk; logic [31:0] hk, lk;
        run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, '0, lat, bk, hk, lk);
        vectors++;
        if (lat !== 33) begin miscompares++; $display("FAIL mult_latency: got %0d want 33", lat); end
        vectors++;
        if (bk !== 1'b1) begin miscompares++; $display("FAIL mult_busy: got %b want 1", bk); end
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            miscompares++; $display("FAIL mult_signed: got %h_%h want ffffffff_ffffffeb", hi, lo);
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %b want 0", busy); end
        @(negedge clock);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse: got %b want 0", done); end
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, lat, bk, hk, lk);
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001 || lat !== 33) begin
            miscompares++; $display("FAIL multu_max: got %h_%h lat %0d want fffffffe_00000001 lat 33", hi, lo, lat);
        end
        @(negedge clock);
    endtask

    task automatic test_div();
        int lat; logic bk; logic [31:0] hk, lk;
        logic [1:0]  ops [5] = '{MD_DIV, MD_DIVU, MD_DIV, MD_DIVU, MD_DIV};
        logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9};
        logic [31:0] bs  [5] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [63:0] exp [5] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                                 64'h0000_0000_8000_0000, 64'h0000_0064_FFFF_FFFF,
                                 64'hFFFF_FFF9_FFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, '0, lat, bk, hk, lk);
            vectors++;
            if ({hi, lo} !== exp[i] || lat !== 33) begin
                miscompares++;
                $display("FAIL div_case%0d: got hi_lo=%h_%h lat %0d want %h lat 33", i, hi, lo, lat, exp[i]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        op = MD_MULT; inA = 32'd5; inB = 32'd6; start = 1'b1;
        @(negedge clock);
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (lat == 4) begin start = 1'b1; op = MD_DIVU; inA = 32'd99; inB = 32'd7; end
            else start = 1'b0;
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        vectors++;
        if ({hi, lo} !== 64'd30 || lat !== 33) begin
            miscompares++; $display("FAIL start_while_busy: got %h_%h lat %0d want 0_30 lat 33", hi, lo, lat);
        end
        op = MD_MULTU; inA = 32'd9; inB = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++; $display("FAIL start_on_done: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin @(negedge clock); lat++; end
        vectors++;
        if ({hi, lo} !== 64'd81 || lat !== 33) begin
            miscompares++; $display("FAIL back_to_back: got %h_%h lat %0d want 0_81 lat 33", hi, lo, lat);
        end
        @(negedge clock);
    endtask

    task automatic test_flush_mthi();
        int lat; int seen; logic bk; logic [31:0] hk, lk;
        hi_wen = 1'b1; wd = 32'h11;
        @(negedge clock);
        hi_wen = 1'b0; lo_wen = 1'b1; wd = 32'h22;
        @(negedge clock);
        lo_wen = 1'b0;
        vectors++;
        if ({hi, lo} !== 64'h0000_0011_0000_0022) begin
            miscompares++; $display("FAIL mthi_mtlo: got %h_%h want 11_22", hi, lo);
        end
        op = MD_DIV; inA = 32'd1000; inB = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL flush_calc: got busy=%b done=%b want 0 0", busy, done);
        end
        seen = 0;
        repeat (40) begin @(negedge clock); if (done === 1'b1) seen++; end
        vectors++;
        if (seen !== 0 || {hi, lo} !== 64'h0000_0011_0000_0022) begin
            miscompares++; $display("FAIL flush_no_result: got done_count=%0d hi_lo=%h_%h want 0 11_22", seen, hi, lo);
        end
        // Flush during the sign-fix cycle also discards the result.
        op = MD_MULTU; inA = 32'd3; inB = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (lat < 32) begin @(negedge clock); lat++; end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'h0000_0011_0000_0022) begin
            miscompares++; $display("FAIL flush_sign: got busy=%b done=%b hi_lo=%h_%h want 0 0 11_22", busy, done, hi, lo);
        end
        // Flush wins over a simultaneous start in idle.
        op = MD_MULTU; inA = 32'd2; inB = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_beats_start: got busy=%b want 0", busy); end
        op = MD_MULTU; inA = 32'd2; inB = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0; hi_wen = 1'b1; wd = 32'hDEAD;
        @(negedge clock);
        hi_wen = 1'b0;
        vectors++;
        if (hi !== 32'h11) begin miscompares++; $display("FAIL mthi_while_busy: got %h want 00000011", hi); end
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin @(negedge clock); lat++; end
        vectors++;
        if ({hi, lo} !== 64'd6) begin miscompares++; $display("FAIL result_after_mthi: got %h_%h want 0_6", hi, lo); end
        @(negedge clock);
        run_op(MD_MULTU, 32'd4, 32'd5, 1'b1, 32'h77, lat, bk, hk, lk);
        vectors++;
        if (hk !== 32'h77 || lk !== 32'h77 || bk !== 1'b1 || {hi, lo} !== 64'd20) begin
            miscompares++;
            $display("FAIL mt_with_start: got hi_k=%h lo_k=%h busy=%b final=%h_%h want 77 77 1 0_20", hk, lk, bk, hi, lo);
        end
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        int lat; logic bk; logic [31:0] hk, lk;
        hi_wen = 1'b1; lo_wen = 1'b1; wd = 32'h55;
        @(negedge clock);
        hi_wen = 1'b0; lo_wen = 1'b0;
        op = MD_MULT; inA = 32'd9; inB = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            miscompares++;
            $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b want all zero", hi, lo, busy, done);
        end
        @(negedge clock);
        reset = 1'b1;
        run_op(MD_MULT, 32'd3, 32'd4, 1'b0, '0, lat, bk, hk, lk);
        vectors++;
        if ({hi, lo} !== 64'd12 || lat !== 33) begin
            miscompares++; $display("FAIL after_reset_mult: got %h_%h lat %0d want 0_12 lat 33", hi, lo, lat);
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        int lat; logic bk; logic [31:0] hk, lk, a, b, mt_d, ehi, elo; logic [1:0] o; bit mt;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
                3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: ;
            endcase
            mt = ($urandom_range(0, 3) == 0);
            mt_d = $urandom;
            model(o, a, b, ehi, elo);
            run_op(o, a, b, mt, mt_d, lat, bk, hk, lk);
            vectors++;
            if ({hi, lo} !== {ehi, elo} || lat !== 33 || bk !== 1'b1) begin
                miscompares++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got %h_%h lat %0d busy %b want %h_%h lat 33 busy 1",
                         i, o, a, b, hi, lo, lat, bk, ehi, elo);
            end
            if (mt) begin
                vectors++;
                if (hk !== mt_d || lk !== mt_d) begin
                    miscompares++; $display("FAIL rand%0d_mt: got %h_%h want %h_%h", i, hk, lk, mt_d, mt_d);
                end
            end
            if ($urandom_range(0, 1) == 0) @(negedge clock);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_flush_mthi();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
